arbitro_memoria_instrucao: RTL and testbench
============================================

Name: arbitro_memoria_instrucao

Overview:
- Shares the single combinational read port of the instruction ROM between two requesters: the fetch stage (requester 0) and the debug/loader read port (requester 1).
- Adds req/gnt/valid handshake, registered address and data, bounds checking and anti-starvation.
- Sits between the fetch unit / debug port and the instruction memory.

Parameters:
- PROFUNDIDADE, 1024, number of 32-bit ROM words; valid addresses are 0..PROFUNDIDADE-1.
- LARGURA, 32, address and data width.
- MAX_ESPERA, 4, consecutive lost arbitrations after which debug is forced to win.
- INSTR_INVALIDA, 32'h00000000, data returned for an out-of-bounds access.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch request; held with fetch_addr stable until fetch_gnt.
- fetch_addr  in  LARGURA  fetch word address.
- fetch_gnt  out  1  one-cycle pulse: request accepted.
- fetch_valid  out  1  one-cycle pulse: fetch_data valid.
- fetch_data  out  LARGURA  returned instruction.
- dbg_req / dbg_addr / dbg_gnt / dbg_valid / dbg_data  same as fetch_*, for requester 1.
- mem_endereco  out  LARGURA  registered address to the ROM.
- mem_instrucao  in  LARGURA  combinational ROM data for mem_endereco.
- erro_limite  out  1  sticky: an out-of-bounds access occurred.
- erro_clr  in  1  synchronous clear of erro_limite.

Behaviour:
- Reset values: all outputs 0 (gnt, valid, data, mem_endereco, erro_limite). FSM goes to OCIOSO. Wait counter is 0.
- FSM states:
  - OCIOSO: if any req is high, arbitrate; register the winner's address into mem_endereco; latch the owner and the oob flag (addr >= PROFUNDIDADE); pulse the winner's gnt; go to ACESSO. Otherwise stay in OCIOSO.
  - ACESSO: capture mem_instrucao, or INSTR_INVALIDA if oob, into the owner's data register. Pulse the owner's valid next cycle. Go to RESPOSTA.
  - RESPOSTA: valid pulse is visible. If any req is high, arbitrate exactly as in OCIOSO (back-to-back) and go to ACESSO; else go to OCIOSO.
- Latency: req sampled at edge N -> gnt high during cycle N+1 -> valid high during cycle N+2. Sustained throughput is one access per 2 cycles.
- Arbitration (default):
  - Fixed priority, fetch over debug.
  - Wait counter increments when dbg_req loses and saturates at MAX_ESPERA.
  - When the counter equals MAX_ESPERA, debug wins the next arbitration.
  - Counter resets to 0 whenever debug is granted or dbg_req is low.
- Only one gnt and one valid are high in any cycle.
- The non-owner's data output holds its previous value.
- Out of bounds:
  - No meaningful ROM read; mem_endereco is still driven with the registered address.
  - Data returned is INSTR_INVALIDA; valid is still pulsed.
  - erro_limite is set on the ACESSO cycle.
  - erro_limite stays set until erro_clr. If set and clear happen in the same cycle, set wins.
- Address check is an unsigned compare on the full LARGURA bits; no wrap-around.
- A req dropped before gnt is a requester protocol violation; the block does not check it.
- Reset mid-operation: the in-flight access is discarded, no valid is emitted, and the FSM returns to OCIOSO immediately.

Optional Feature:
- ROUND_ROBIN_EN defined: the wait counter is removed. A last-winner register alternates priority; the requester not granted last wins a tie. Its reset value is fetch-was-last, so debug wins the first tie.
- ROUND_ROBIN_EN undefined: fixed priority with the MAX_ESPERA anti-starvation rule above.

Decomposition:
- Shared package pkg_memoria_instrucao:
  - estado_arbitro_t enum (OCIOSO, ACESSO, RESPOSTA);
  - REQ_FETCH=0 and REQ_DBG=1 owner constants;
  - default PROFUNDIDADE and INSTR_INVALIDA.
- One natural sub-module, arbitro_prioridade: combinational winner select plus the wait-counter / last-winner register. The FSM and datapath stay in the top.

Test Plan:
- Fetch only, fetch_addr=5, ROM[5]=32'hDEADBEEF -> fetch_gnt in cycle 1, fetch_valid with fetch_data=32'hDEADBEEF in cycle 2; dbg outputs remain 0.
- fetch_req and dbg_req held high continuously (default build, MAX_ESPERA=4) -> grants fetch,fetch,fetch,fetch,dbg, repeating; with ROUND_ROBIN_EN -> dbg,fetch,dbg,fetch.
- dbg_addr=1024 -> dbg_valid with dbg_data=32'h0, erro_limite=1 and held; erro_clr for one cycle -> erro_limite=0.
- Back-to-back fetch at addresses 0,1,2 with req held -> gnt every 2 cycles, valid data ROM[0],ROM[1],ROM[2] in order, no idle cycle between accesses.
- reset_n asserted during ACESSO -> all outputs 0 asynchronously, no valid after release, next request is served normally with 2-cycle latency.
- erro_clr and a new out-of-bounds access in the same cycle -> erro_limite remains 1.

Source files
------------

// File: rtl/arbitro_memoria_instrucao_pkg.sv
// rtl/arbitro_memoria_instrucao_pkg.sv - shared types, owner ids and defaults for the instruction-ROM arbiter
package pkg_memoria_instrucao;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_arbitro_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DBG   = 1'b1;

  localparam int          PROFUNDIDADE_PADRAO   = 1024;
  localparam int          LARGURA_PADRAO        = 32;
  localparam int          MAX_ESPERA_PADRAO     = 4;
  localparam logic [31:0] INSTR_INVALIDA_PADRAO = 32'h0000_0000;

endpackage

// File: rtl/arbitro_memoria_instrucao_if.sv
// rtl/arbitro_memoria_instrucao_if.sv - requester, ROM and error signals of the instruction-ROM arbiter
interface arbitro_memoria_instrucao_if #(
  parameter int LARGURA = 32
);

  logic               fetch_req;
  logic [LARGURA-1:0] fetch_addr;
  logic               fetch_gnt;
  logic               fetch_valid;
  logic [LARGURA-1:0] fetch_data;

  logic               dbg_req;
  logic [LARGURA-1:0] dbg_addr;
  logic               dbg_gnt;
  logic               dbg_valid;
  logic [LARGURA-1:0] dbg_data;

  logic [LARGURA-1:0] mem_endereco;
  logic [LARGURA-1:0] mem_instrucao;

  logic               erro_limite;
  logic               erro_clr;

  modport slave (
    input  fetch_req, fetch_addr, dbg_req, dbg_addr, mem_instrucao, erro_clr,
    output fetch_gnt, fetch_valid, fetch_data,
    output dbg_gnt, dbg_valid, dbg_data,
    output mem_endereco, erro_limite
  );

  modport master (
    output fetch_req, fetch_addr, dbg_req, dbg_addr, mem_instrucao, erro_clr,
    input  fetch_gnt, fetch_valid, fetch_data,
    input  dbg_gnt, dbg_valid, dbg_data,
    input  mem_endereco, erro_limite
  );

endinterface

// File: rtl/arbitro_memoria_instrucao_prioridade.sv
// rtl/arbitro_memoria_instrucao_prioridade.sv - winner select with anti-starvation counter
// ROUND_ROBIN_EN swaps the counter for a last-winner register that alternates priority on ties.
module arbitro_prioridade
  import pkg_memoria_instrucao::*;
#(
  parameter int MAX_ESPERA = MAX_ESPERA_PADRAO
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_fetch_req,
  input  logic i_dbg_req,
  input  logic i_arbitra,
  output logic o_vencedor
);

`ifdef ROUND_ROBIN_EN

  logic r_ultimo;

  always_comb begin
    o_vencedor = REQ_FETCH;
    if (i_fetch_req && i_dbg_req) begin
      o_vencedor = ~r_ultimo;
    end else if (i_dbg_req) begin
      o_vencedor = REQ_DBG;
    end
  end

  // Reset value makes debug the winner of the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ultimo <= REQ_FETCH;
    end else if (i_arbitra) begin
      r_ultimo <= o_vencedor;
    end
  end

`else

  localparam int             W_ESPERA = $clog2(MAX_ESPERA + 1);
  localparam logic [W_ESPERA-1:0] LIMITE_ESPERA = W_ESPERA'(MAX_ESPERA);

  logic [W_ESPERA-1:0] r_espera;
  logic                w_forca_dbg;

  assign w_forca_dbg = (r_espera == LIMITE_ESPERA);

  always_comb begin
    o_vencedor = REQ_FETCH;
    if (i_dbg_req && (!i_fetch_req || w_forca_dbg)) begin
      o_vencedor = REQ_DBG;
    end
  end

  // Counts consecutive arbitrations debug lost while it kept asking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_espera <= '0;
    end else if (!i_dbg_req) begin
      r_espera <= '0;
    end else if (i_arbitra) begin
      if (o_vencedor == REQ_DBG) begin
        r_espera <= '0;
      end else if (!w_forca_dbg) begin
        r_espera <= r_espera + W_ESPERA'(1);
      end
    end
  end

`endif

endmodule

// File: rtl/arbitro_memoria_instrucao.sv
// rtl/arbitro_memoria_instrucao.sv - shares the instruction-ROM read port between fetch and debug
// Priority scheme comes from arbitro_prioridade; ROUND_ROBIN_EN selects round-robin instead of fixed+anti-starvation.
module arbitro_memoria_instrucao
  import pkg_memoria_instrucao::*;
#(
  parameter int                 PROFUNDIDADE   = PROFUNDIDADE_PADRAO,
  parameter int                 LARGURA        = LARGURA_PADRAO,
  parameter int                 MAX_ESPERA     = MAX_ESPERA_PADRAO,
  parameter logic [LARGURA-1:0] INSTR_INVALIDA = LARGURA'(INSTR_INVALIDA_PADRAO)
) (
  input logic                       clock,
  input logic                       reset_n,
  arbitro_memoria_instrucao_if.slave bus
);

  localparam logic [1:0] ST_OCIOSO   = OCIOSO;
  localparam logic [1:0] ST_ACESSO   = ACESSO;
  localparam logic [1:0] ST_RESPOSTA = RESPOSTA;

  localparam logic [LARGURA-1:0] LIMITE = LARGURA'(PROFUNDIDADE);

  logic [1:0]         r_estado;
  logic               r_dono;
  logic               r_fora;
  logic [LARGURA-1:0] r_endereco;
  logic               r_fetch_gnt;
  logic               r_dbg_gnt;
  logic               r_fetch_valid;
  logic               r_dbg_valid;
  logic [LARGURA-1:0] r_fetch_data;
  logic [LARGURA-1:0] r_dbg_data;
  logic               r_erro;

  logic               w_pode_arbitrar;
  logic               w_arbitra;
  logic               w_vencedor;
  logic [LARGURA-1:0] w_addr_vencedor;
  logic [LARGURA-1:0] w_dado;
  logic               w_define_erro;

  assign w_pode_arbitrar = (r_estado == ST_OCIOSO) || (r_estado == ST_RESPOSTA);
  assign w_arbitra       = w_pode_arbitrar && (bus.fetch_req || bus.dbg_req);
  assign w_addr_vencedor = (w_vencedor == REQ_DBG) ? bus.dbg_addr : bus.fetch_addr;
  assign w_dado          = r_fora ? INSTR_INVALIDA : bus.mem_instrucao;
  assign w_define_erro   = (r_estado == ST_ACESSO) && r_fora;

  arbitro_prioridade #(
    .MAX_ESPERA (MAX_ESPERA)
  ) u_prioridade (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_fetch_req (bus.fetch_req),
    .i_dbg_req   (bus.dbg_req),
    .i_arbitra   (w_arbitra),
    .o_vencedor  (w_vencedor)
  );

  // RESPOSTA arbitrates like OCIOSO so held requests get one access every two cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado      <= ST_OCIOSO;
      r_dono        <= REQ_FETCH;
      r_fora        <= 1'b0;
      r_endereco    <= '0;
      r_fetch_gnt   <= 1'b0;
      r_dbg_gnt     <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_dbg_valid   <= 1'b0;
      r_fetch_data  <= '0;
      r_dbg_data    <= '0;
    end else begin
      r_fetch_gnt   <= 1'b0;
      r_dbg_gnt     <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_dbg_valid   <= 1'b0;
      case (r_estado)
        ST_OCIOSO, ST_RESPOSTA: begin
          if (w_arbitra) begin
            r_estado    <= ST_ACESSO;
            r_endereco  <= w_addr_vencedor;
            r_dono      <= w_vencedor;
            r_fora      <= (w_addr_vencedor >= LIMITE);
            r_fetch_gnt <= (w_vencedor == REQ_FETCH);
            r_dbg_gnt   <= (w_vencedor == REQ_DBG);
          end else begin
            r_estado <= ST_OCIOSO;
          end
        end
        ST_ACESSO: begin
          r_estado <= ST_RESPOSTA;
          if (r_dono == REQ_DBG) begin
            r_dbg_data  <= w_dado;
            r_dbg_valid <= 1'b1;
          end else begin
            r_fetch_data  <= w_dado;
            r_fetch_valid <= 1'b1;
          end
        end
        default: begin
          r_estado <= ST_OCIOSO;
        end
      endcase
    end
  end

  // A new out-of-bounds access outranks a clear arriving in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_erro <= 1'b0;
    end else if (w_define_erro) begin
      r_erro <= 1'b1;
    end else if (bus.erro_clr) begin
      r_erro <= 1'b0;
    end
  end

  assign bus.fetch_gnt    = r_fetch_gnt;
  assign bus.dbg_gnt      = r_dbg_gnt;
  assign bus.fetch_valid  = r_fetch_valid;
  assign bus.dbg_valid    = r_dbg_valid;
  assign bus.fetch_data   = r_fetch_data;
  assign bus.dbg_data     = r_dbg_data;
  assign bus.mem_endereco = r_endereco;
  assign bus.erro_limite  = r_erro;

endmodule

// File: tb/tb_arbitro_memoria_instrucao.sv
// tb/tb_arbitro_memoria_instrucao.sv - self-checking bench for arbitro_memoria_instrucao
module tb_arbitro_memoria_instrucao;
  import pkg_memoria_instrucao::*;

  localparam int          PROF     = 1024;
  localparam int          MAXE     = 4;
  localparam logic [31:0] INVALIDA = 32'h0000_0000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  logic [31:0] rom [PROF];

  always #5 clock = ~clock;

  arbitro_memoria_instrucao_if #(.LARGURA(32)) bus ();

  arbitro_memoria_instrucao #(
    .PROFUNDIDADE   (PROF),
    .LARGURA        (32),
    .MAX_ESPERA     (MAXE),
    .INSTR_INVALIDA (INVALIDA)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Out-of-range reads return garbage so a missing substitution is visible.
  assign bus.mem_instrucao = (bus.mem_endereco < 32'(PROF)) ? rom[bus.mem_endereco[9:0]] : 32'hBAD0_BAD0;

  task automatic entradas_zero();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.dbg_req    = 1'b0;
    bus.dbg_addr   = '0;
    bus.erro_clr   = 1'b0;
  endtask

  function automatic logic [31:0] endereco_aleatorio();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return 32'(PROF) + 32'($urandom_range(0, 3));
    if (s == 1) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, PROF - 1));
  endfunction

  task automatic test_reset();
    entradas_zero();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.fetch_gnt, bus.dbg_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got %b%b want 00", bus.fetch_gnt, bus.dbg_gnt);
    end
    checks++;
    if ({bus.fetch_valid, bus.dbg_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_valid got %b%b want 00", bus.fetch_valid, bus.dbg_valid);
    end
    checks++;
    if (bus.fetch_data !== 32'h0 || bus.dbg_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h %h want 0 0", bus.fetch_data, bus.dbg_data);
    end
    checks++;
    if (bus.mem_endereco !== 32'h0 || bus.erro_limite !== 1'b0) begin
      errors++; $display("FAIL reset_mem_erro got %h %b want 0 0", bus.mem_endereco, bus.erro_limite);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_fetch_only();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'd5;
    @(negedge clock);
    checks++;
    if (bus.fetch_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0 || bus.fetch_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_gnt got gnt=%b dbg_gnt=%b valid=%b want 1 0 0", bus.fetch_gnt, bus.dbg_gnt, bus.fetch_valid);
    end
    bus.fetch_req = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'hDEADBEEF || bus.fetch_gnt !== 1'b0) begin
      errors++; $display("FAIL fetch_valid got valid=%b data=%h gnt=%b want 1 deadbeef 0", bus.fetch_valid, bus.fetch_data, bus.fetch_gnt);
    end
    checks++;
    if ({bus.dbg_gnt, bus.dbg_valid} !== 2'b00 || bus.dbg_data !== 32'h0) begin
      errors++; $display("FAIL fetch_dbg_quiet got %b%b %h want 00 0", bus.dbg_gnt, bus.dbg_valid, bus.dbg_data);
    end
    @(negedge clock);
    checks++;
    if (bus.fetch_valid !== 1'b0 || bus.fetch_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fetch_hold got valid=%b data=%h want 0 deadbeef", bus.fetch_valid, bus.fetch_data);
    end
  endtask

  task automatic test_contention();
    logic obs[$];
    logic esperado;
    logic dupla;
    int   perdas;
    logic ultimo;
    dupla  = 1'b0;
    perdas = 0;
    ultimo = REQ_FETCH;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'($urandom_range(0, PROF - 1));
    bus.dbg_req    = 1'b1;
    bus.dbg_addr   = 32'($urandom_range(0, PROF - 1));
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (bus.fetch_gnt && bus.dbg_gnt) dupla = 1'b1;
      if (bus.fetch_gnt) obs.push_back(REQ_FETCH);
      if (bus.dbg_gnt) obs.push_back(REQ_DBG);
    end
    entradas_zero();
    repeat (3) @(negedge clock);
    checks++;
    if (obs.size() != 10) begin
      errors++; $display("FAIL contention_count got %0d grants want 10", obs.size());
    end
    for (int i = 0; i < 10 && i < obs.size(); i++) begin
`ifdef ROUND_ROBIN_EN
      esperado = ~ultimo;
      ultimo   = esperado;
`else
      if (perdas == MAXE) begin
        esperado = REQ_DBG;
        perdas   = 0;
      end else begin
        esperado = REQ_FETCH;
        perdas++;
      end
`endif
      checks++;
      if (obs[i] !== esperado) begin
        errors++; $display("FAIL contention_order grant %0d got %b want %b", i, obs[i], esperado);
      end
    end
    checks++;
    if (dupla !== 1'b0) begin
      errors++; $display("FAIL contention_double_gnt got 1 want 0");
    end
  endtask

  task automatic test_oob();
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 32'd1024;
    @(negedge clock);
    checks++;
    if (bus.dbg_gnt !== 1'b1 || bus.mem_endereco !== 32'd1024) begin
      errors++; $display("FAIL oob_gnt got gnt=%b mem=%h want 1 400", bus.dbg_gnt, bus.mem_endereco);
    end
    bus.dbg_req = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.dbg_valid !== 1'b1 || bus.dbg_data !== INVALIDA || bus.erro_limite !== 1'b1) begin
      errors++; $display("FAIL oob_valid got valid=%b data=%h erro=%b want 1 0 1", bus.dbg_valid, bus.dbg_data, bus.erro_limite);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (bus.erro_limite !== 1'b1) begin
      errors++; $display("FAIL oob_sticky got %b want 1", bus.erro_limite);
    end
    bus.erro_clr = 1'b1;
    @(negedge clock);
    bus.erro_clr = 1'b0;
    checks++;
    if (bus.erro_limite !== 1'b0) begin
      errors++; $display("FAIL oob_clear got %b want 0", bus.erro_limite);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic exp_gnt;
    logic exp_val;
    n = 0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'd0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clock);
      exp_gnt = (cyc % 2 == 1) && (cyc <= 5);
      exp_val = (cyc % 2 == 0) && (cyc <= 6);
      checks++;
      if (bus.fetch_gnt !== exp_gnt || bus.fetch_valid !== exp_val) begin
        errors++; $display("FAIL b2b_timing cycle %0d got gnt=%b valid=%b want %b %b", cyc, bus.fetch_gnt, bus.fetch_valid, exp_gnt, exp_val);
      end
      if (exp_val) begin
        checks++;
        if (bus.fetch_data !== rom[cyc / 2 - 1]) begin
          errors++; $display("FAIL b2b_data cycle %0d got %h want %h", cyc, bus.fetch_data, rom[cyc / 2 - 1]);
        end
      end
      if (bus.fetch_gnt) begin
        n++;
        if (n < 3) bus.fetch_addr = 32'(n);
        else bus.fetch_req = 1'b0;
      end
    end
    entradas_zero();
  endtask

  task automatic test_reset_mid();
    logic [31:0] b;
    logic        viu_valid;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'($urandom_range(0, PROF - 1));
    @(negedge clock);
    checks++;
    if (bus.fetch_gnt !== 1'b1) begin
      errors++; $display("FAIL rmid_gnt got %b want 1", bus.fetch_gnt);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.fetch_gnt, bus.fetch_valid, bus.dbg_gnt, bus.dbg_valid, bus.erro_limite} !== 5'b0 ||
        bus.fetch_data !== 32'h0 || bus.dbg_data !== 32'h0 || bus.mem_endereco !== 32'h0) begin
      errors++; $display("FAIL rmid_async got gnt=%b data=%h mem=%h want all 0", bus.fetch_gnt, bus.fetch_data, bus.mem_endereco);
    end
    entradas_zero();
    @(negedge clock);
    reset_n   = 1'b1;
    viu_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      viu_valid = viu_valid | bus.fetch_valid | bus.dbg_valid;
    end
    checks++;
    if (viu_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_no_valid got 1 want 0");
    end
    b = 32'($urandom_range(0, PROF - 1));
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = b;
    @(negedge clock);
    checks++;
    if (bus.fetch_gnt !== 1'b1) begin
      errors++; $display("FAIL rmid_next_gnt got %b want 1", bus.fetch_gnt);
    end
    bus.fetch_req = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== rom[b[9:0]]) begin
      errors++; $display("FAIL rmid_next_valid got %b %h want 1 %h", bus.fetch_valid, bus.fetch_data, rom[b[9:0]]);
    end
    @(negedge clock);
  endtask

  task automatic test_clr_and_set();
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 32'hFFFF_FFF0;
    @(negedge clock);
    checks++;
    if (bus.dbg_gnt !== 1'b1) begin
      errors++; $display("FAIL clrset_gnt got %b want 1", bus.dbg_gnt);
    end
    bus.dbg_req  = 1'b0;
    bus.erro_clr = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.erro_limite !== 1'b1 || bus.dbg_valid !== 1'b1 || bus.dbg_data !== INVALIDA) begin
      errors++; $display("FAIL clrset_set_wins got erro=%b valid=%b data=%h want 1 1 0", bus.erro_limite, bus.dbg_valid, bus.dbg_data);
    end
    @(negedge clock);
    bus.erro_clr = 1'b0;
    checks++;
    if (bus.erro_limite !== 1'b0) begin
      errors++; $display("FAIL clrset_later_clear got %b want 0", bus.erro_limite);
    end
  endtask

  task automatic test_random();
    logic        ocupado, dono, fora, w, define;
    logic [31:0] areg, e_df, e_dd;
    logic        e_gf, e_gd, e_vf, e_vd, e_err;
    logic        n_gf, n_gd, n_vf, n_vd;
    int          perdas;
    logic        ultimo;
    ocupado = 0; dono = 0; fora = 0; areg = 0; e_df = 0; e_dd = 0;
    e_gf = 0; e_gd = 0; e_vf = 0; e_vd = 0; e_err = 0;
    perdas = 0; ultimo = REQ_FETCH;
    entradas_zero();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (bus.fetch_gnt !== e_gf || bus.dbg_gnt !== e_gd) begin
        errors++; $display("FAIL rand_gnt cycle %0d got %b%b want %b%b", c, bus.fetch_gnt, bus.dbg_gnt, e_gf, e_gd);
      end
      checks++;
      if (bus.fetch_valid !== e_vf || bus.dbg_valid !== e_vd) begin
        errors++; $display("FAIL rand_valid cycle %0d got %b%b want %b%b", c, bus.fetch_valid, bus.dbg_valid, e_vf, e_vd);
      end
      checks++;
      if (bus.fetch_data !== e_df || bus.dbg_data !== e_dd) begin
        errors++; $display("FAIL rand_data cycle %0d got %h %h want %h %h", c, bus.fetch_data, bus.dbg_data, e_df, e_dd);
      end
      checks++;
      if (bus.mem_endereco !== areg || bus.erro_limite !== e_err) begin
        errors++; $display("FAIL rand_mem_erro cycle %0d got %h %b want %h %b", c, bus.mem_endereco, bus.erro_limite, areg, e_err);
      end
      // Requesters react to the grant they were promised, then maybe ask again.
      if (e_gf) bus.fetch_req = 1'b0;
      if (e_gd) bus.dbg_req = 1'b0;
      if (!bus.fetch_req && $urandom_range(0, 2) == 0) begin
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = endereco_aleatorio();
      end
      if (!bus.dbg_req && $urandom_range(0, 2) == 0) begin
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = endereco_aleatorio();
      end
      bus.erro_clr = ($urandom_range(0, 9) == 0);
      n_gf = 0; n_gd = 0; n_vf = 0; n_vd = 0; define = 0;
      if (ocupado) begin
        ocupado = 0;
        define  = fora;
        if (dono == REQ_DBG) begin
          e_dd = fora ? INVALIDA : rom[areg[9:0]];
          n_vd = 1;
        end else begin
          e_df = fora ? INVALIDA : rom[areg[9:0]];
          n_vf = 1;
        end
      end else if (bus.fetch_req || bus.dbg_req) begin
`ifdef ROUND_ROBIN_EN
        if (bus.fetch_req && bus.dbg_req) w = ~ultimo;
        else w = bus.dbg_req ? REQ_DBG : REQ_FETCH;
        ultimo = w;
`else
        w = (bus.dbg_req && (!bus.fetch_req || perdas == MAXE)) ? REQ_DBG : REQ_FETCH;
        if (w == REQ_DBG) perdas = 0;
        else if (perdas < MAXE) perdas++;
`endif
        ocupado = 1;
        dono    = w;
        areg    = (w == REQ_DBG) ? bus.dbg_addr : bus.fetch_addr;
        fora    = (areg >= 32'(PROF));
        n_gf    = (w == REQ_FETCH);
        n_gd    = (w == REQ_DBG);
      end
      if (!bus.dbg_req) perdas = 0;
      if (define) e_err = 1'b1;
      else if (bus.erro_clr) e_err = 1'b0;
      e_gf = n_gf; e_gd = n_gd; e_vf = n_vf; e_vd = n_vd;
      @(negedge clock);
    end
    entradas_zero();
  endtask

  initial begin
    for (int i = 0; i < PROF; i++) rom[i] = $urandom;
    rom[5] = 32'hDEADBEEF;
    test_reset();
    test_fetch_only();
    test_contention();
    test_oob();
    test_back_to_back();
    test_reset_mid();
    test_clr_and_set();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
